// File: rtl/car_sequencer.sv
// Elevator car sequencer: turns controller commands into hoist and door drives,
// tracks the car floor and reports serve completion and impossible moves.
module car_sequencer #(
  parameter int N             = 4,
  parameter int F_BITS        = $clog2(N),
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int DWELL_CYCLES  = 16,
  parameter int HOLDOFF       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        command,
  input  logic              door_block,
  output logic [F_BITS-1:0] cur_floor,
  output logic              motor_up,
  output logic              motor_down,
  output logic              door_open_cmd,
  output logic              door_close_cmd,
  output logic              door_is_open,
  output logic              served_pulse,
  output logic              busy,
  output logic              cmd_err
);

  localparam int MAX_AB  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int MAX_CYC = (MAX_AB > DWELL_CYCLES) ? MAX_AB : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [CNT_W-1:0]  TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [F_BITS-1:0] TOP_FLOOR   = F_BITS'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_OPENING,
    S_DWELL,
    S_CLOSING
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [F_BITS-1:0]   floor_d;
  logic                served_d, err_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    hold_d   = hold_q;
    floor_d  = cur_floor;
    served_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          case (command)
            2'b01: if (cur_floor != TOP_FLOOR) state_d = S_MOVE_UP;
                   else err_d = ~cmd_err;
            2'b10: if (cur_floor != '0) state_d = S_MOVE_DOWN;
                   else err_d = ~cmd_err;
            2'b11: state_d = S_OPENING;
            default: ;
          endcase
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (cnt_q == TRAVEL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          floor_d = (state_q == S_MOVE_UP) ? cur_floor + F_BITS'(1)
                                           : cur_floor - F_BITS'(1);
        end
      end
      S_OPENING: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = S_DWELL;
          cnt_d   = '0;
        end
      end
      S_DWELL: begin
        // An obstruction restarts the whole dwell rather than extending it.
        if (door_block) begin
          cnt_d = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_CLOSING;
          cnt_d   = '0;
        end
      end
      S_CLOSING: begin
        if (door_block) begin
          state_d = S_OPENING;
          cnt_d   = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          hold_d   = HOLD_W'(HOLDOFF);
          served_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      hold_q         <= '0;
      cur_floor      <= '0;
      motor_up       <= 1'b0;
      motor_down     <= 1'b0;
      door_open_cmd  <= 1'b0;
      door_close_cmd <= 1'b0;
      door_is_open   <= 1'b0;
      served_pulse   <= 1'b0;
      busy           <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      cur_floor      <= floor_d;
      // Drives decode the state being entered, so they change on the same edge.
      motor_up       <= (state_d == S_MOVE_UP);
      motor_down     <= (state_d == S_MOVE_DOWN);
      door_open_cmd  <= (state_d == S_OPENING);
      door_close_cmd <= (state_d == S_CLOSING);
      door_is_open   <= (state_d == S_DWELL);
      served_pulse   <= served_d;
      busy           <= (state_d != S_IDLE) || (hold_d != '0);
      cmd_err        <= err_d;
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: directed scenarios plus random commands, all checked
// every edge against a timestamp-based model of the car's activities.
module tb_car_sequencer;

  localparam int N      = 4;
  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;
  localparam int DWELL  = 16;
  localparam int HOLD   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] command = 2'b00;
  logic       door_block = 1'b0;
  logic [1:0] cur_floor;
  logic motor_up, motor_down, door_open_cmd, door_close_cmd, door_is_open;
  logic served_pulse, busy, cmd_err;

  car_sequencer #(
    .N(N), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR),
    .DWELL_CYCLES(DWELL), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .door_block(door_block),
    .cur_floor(cur_floor), .motor_up(motor_up), .motor_down(motor_down),
    .door_open_cmd(door_open_cmd), .door_close_cmd(door_close_cmd),
    .door_is_open(door_is_open), .served_pulse(served_pulse),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the car is doing and the edge at which it started.
  localparam int A_IDLE = 0, A_UP = 1, A_DOWN = 2, A_OPEN = 3, A_DWELL = 4, A_CLOSE = 5;
  int act = A_IDLE;
  int act_start = 0;
  int m_floor = 0;
  int edge_n = 0;
  int last_served = -1000;
  bit m_served = 1'b0;
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {cur_floor, motor_up, motor_down, door_open_cmd, door_close_cmd,
            door_is_open, served_pulse, busy, cmd_err};
  endfunction

  function automatic bit model_busy();
    return (act != A_IDLE) || (edge_n < last_served + HOLD);
  endfunction

  function automatic logic [9:0] exp_vec();
    return {2'(m_floor), act == A_UP, act == A_DOWN, act == A_OPEN, act == A_CLOSE,
            act == A_DWELL, m_served, model_busy(), m_err};
  endfunction

  task automatic model_reset();
    act = A_IDLE; act_start = edge_n; m_floor = 0;
    last_served = -1000; m_served = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] c, input logic b);
    bit err_now;
    bit srv;
    err_now = 1'b0;
    srv = 1'b0;
    edge_n++;
    case (act)
      A_IDLE:
        if (edge_n > last_served + HOLD) begin
          if (c == 2'b01) begin
            if (m_floor < N - 1) begin act = A_UP; act_start = edge_n; end
            else err_now = !m_err;
          end else if (c == 2'b10) begin
            if (m_floor > 0) begin act = A_DOWN; act_start = edge_n; end
            else err_now = !m_err;
          end else if (c == 2'b11) begin
            act = A_OPEN; act_start = edge_n;
          end
        end
      A_UP:   if (edge_n - act_start == TRAVEL) begin m_floor++; act = A_IDLE; end
      A_DOWN: if (edge_n - act_start == TRAVEL) begin m_floor--; act = A_IDLE; end
      A_OPEN: if (edge_n - act_start == DOOR) begin act = A_DWELL; act_start = edge_n; end
      A_DWELL:
        if (b) act_start = edge_n;
        else if (edge_n - act_start == DWELL) begin act = A_CLOSE; act_start = edge_n; end
      A_CLOSE:
        if (b) begin act = A_OPEN; act_start = edge_n; end
        else if (edge_n - act_start == DOOR) begin
          act = A_IDLE; srv = 1'b1; last_served = edge_n;
        end
      default: act = A_IDLE;
    endcase
    m_served = srv;
    m_err = err_now;
  endtask

  task automatic step(input logic [1:0] c, input logic b);
    command = c;
    door_block = b;
    @(posedge clk);
    #1;
    model_edge(c, b);
    check("model", obs_vec(), exp_vec());
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", obs_vec(), 10'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((act != A_IDLE || model_busy()) && n < 200) begin
      step(2'b00, 1'b0);
      n++;
    end
    check("settle_budget", 10'(n < 200), 10'd1);
    check("settle_busy", 10'(busy), 10'd0);
  endtask

  initial begin
    // 1: reset behaviour
    #12;
    check("reset_hold", obs_vec(), 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
    for (int i = 0; i < 9; i++) step((i == 0) ? 2'b01 : 2'b00, 1'b0);
    check("pre_reset_floor", 10'(cur_floor), 10'd1);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    mid_reset();
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
    check("post_reset_busy", 10'(busy), 10'd0);

    // 2: multi-floor up, held command
    for (int i = 0; i < 28; i++) begin
      step(2'b01, 1'b0);
      if (i == 8)  check("up_floor1", 10'(cur_floor), 10'd1);
      if (i == 17) check("up_floor2", 10'(cur_floor), 10'd2);
      if (i == 26) check("up_floor3", 10'(cur_floor), 10'd3);
    end
    check("top_err", 10'({motor_up, cmd_err}), 10'b01);

    // 3: serve with 11 held, holdoff then reopen
    for (int i = 0; i < 29; i++) begin
      step(2'b11, 1'b0);
      check("serve_doors",
            10'({door_open_cmd, door_is_open, door_close_cmd, served_pulse}),
            10'({(i <= 3 || i == 28), (i >= 4 && i <= 19),
                 (i >= 20 && i <= 23), (i == 24)}));
    end
    settle();

    // 4: obstruction during dwell
    for (int i = 0; i < 31; i++) begin
      step((i == 0) ? 2'b11 : 2'b00, (i == 10));
      check("dwell_block",
            10'({door_close_cmd, served_pulse}),
            10'({(i >= 26 && i <= 29), (i == 30)}));
    end
    settle();

    // 5: obstruction during closing
    for (int i = 0; i < 47; i++) begin
      step((i == 0) ? 2'b11 : 2'b00, (i == 22));
      check("close_block",
            10'({door_open_cmd, served_pulse}),
            10'({(i <= 3 || (i >= 22 && i <= 25)), (i == 46)}));
    end
    settle();

    // 6: bottom boundary, then one floor up and back down
    step(2'b00, 1'b0);
    mid_reset();
    step(2'b10, 1'b0);
    check("bottom_err", 10'({cmd_err, motor_down, cur_floor}), 10'b1000);
    step(2'b00, 1'b0);
    check("bottom_err_once", 10'(cmd_err), 10'd0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        step((i == 0) ? ((d == 0) ? 2'b01 : 2'b10) : 2'b00, 1'b0);
        check("move_drive", 10'({busy, motor_up, motor_down}),
              (i < 8) ? ((d == 0) ? 10'b110 : 10'b101) : 10'b000);
      end
      check("move_floor", 10'(cur_floor), (d == 0) ? 10'd1 : 10'd0);
    end

    // Random commands and obstructions, with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      if (i % 700 == 699) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/car_sequencer.md
# car_sequencer

Sequences the elevator car's motor and doors from the 2-bit command issued by the elevator controller (00 idle, 01 up, 10 down, 11 serve). It owns the car position (`cur_floor`) and the motor and door drive outputs. It returns a one-cycle `served_pulse` when a serve cycle finishes, which clears the served buttons. It sits between the controller and the physical car/door actuators.

## Interface
- `N`, 4, number of floors (≥2)
- `F_BITS`, `$clog2(N)`, floor index width
- `TRAVEL_CYCLES`, 8, clocks to move one floor (≥1)
- `DOOR_CYCLES`, 4, clocks to fully open or fully close the doors (≥1)
- `DWELL_CYCLES`, 16, clocks the doors stay open (≥1)
- `HOLDOFF`, 3, clocks commands are ignored after a serve completes (≥0)

Ports:
- `clk`, in, 1, clock
- `rst_n`, in, 1, reset; asynchronous, active-low
- `command`, in, 2, controller command
- `door_block`, in, 1, door obstruction sensor (level)
- `cur_floor`, out, F_BITS, current car floor
- `motor_up`, out, 1, hoist drive up
- `motor_down`, out, 1, hoist drive down
- `door_open_cmd`, out, 1, door motor opening
- `door_close_cmd`, out, 1, door motor closing
- `door_is_open`, out, 1, doors fully open (dwell)
- `served_pulse`, out, 1, one-cycle pulse when a serve cycle finishes
- `busy`, out, 1, high when state ≠ IDLE or holdoff is active
- `cmd_err`, out, 1, one-cycle pulse when an impossible move is requested

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, OPENING, DWELL, CLOSING. A single cycle counter `cnt` is reloaded to 0 on every state entry.
- All outputs are registered and decoded from the state entered at that edge:
  - `motor_up` = MOVE_UP
  - `motor_down` = MOVE_DOWN
  - `door_open_cmd` = OPENING
  - `door_is_open` = DWELL
  - `door_close_cmd` = CLOSING
- IDLE: `command` is sampled each edge unless holdoff is active.
  - 01 with `cur_floor` < N-1 → MOVE_UP.
  - 10 with `cur_floor` > 0 → MOVE_DOWN.
  - 11 → OPENING.
  - 00 → stay in IDLE.
  - 01 at floor N-1, or 10 at floor 0 → stay in IDLE and pulse `cmd_err` for 1 cycle.
- MOVE_x: commands are ignored. On the edge where `cnt` = TRAVEL_CYCLES-1, `cur_floor` steps ±1 and the state returns to IDLE. A move covers exactly one floor; the controller re-decides at each floor.
- OPENING: after DOOR_CYCLES → DWELL. `door_block` is ignored.
- DWELL: after DWELL_CYCLES → CLOSING. `door_block` sampled high reloads `cnt` to 0, restarting the full dwell.
- CLOSING: after DOOR_CYCLES → IDLE, with `served_pulse` high for exactly that cycle. `door_block` sampled high at any edge in CLOSING → OPENING, with `cnt` reset and a full reopen. Only completion of CLOSING produces `served_pulse`.
- Holdoff: entering IDLE from CLOSING loads a holdoff counter with HOLDOFF. Commands at the next HOLDOFF edges are ignored, which covers the controller's clear and command latency so a stale 11 does not reopen the doors. Holdoff does not apply after a move.
- `cnt` width is `$clog2` of the largest of TRAVEL_CYCLES, DOOR_CYCLES, DWELL_CYCLES, plus 1. `cur_floor` never leaves 0..N-1.

## Timing
- Reset (async assert) sets everything to 0 immediately: all outputs, `cur_floor`, `cnt`, holdoff, and state IDLE.
  - Reset mid-move or mid-door drops all drives at once. Car position is not recovered; re-homing is out of scope.
- Command-to-action latency is 1 edge. A command sampled at edge k drives the new output from edge k.
- Move: entered at edge k → `cur_floor` updates and `motor_*` drops at edge k+TRAVEL_CYCLES. With the command held, the next move starts at k+TRAVEL_CYCLES+1.
- Serve: entered at edge k, with no obstruction:
  - OPENING at edges k..k+D-1
  - DWELL from edge k+D
  - CLOSING from edge k+D+W
  - IDLE with `served_pulse` at edge k+2D+W
  - first command acted on at edge k+2D+W+HOLDOFF+1
- `served_pulse` and `cmd_err` are never high for two consecutive cycles and are never high together.

## Test plan
1. Reset: assert `rst_n`=0 mid-stream → all outputs 0 and `cur_floor`=0 asynchronously. After release with `command`=00 → outputs stay 0 and `busy`=0.
2. Multi-floor up: `command`=01 held from edge 0 at floor 0 → `cur_floor`=1 at edge 8, 2 at edge 17, 3 at edge 26. At edge 27, `cmd_err` pulses and `motor_up` stays 0.
3. Serve: `command`=11 held from edge 0 →
   - `door_open_cmd` at edges 0-3
   - `door_is_open` at edges 4-19
   - `door_close_cmd` at edges 20-23
   - `served_pulse` only at edge 24
   - the still-held 11 is ignored through edge 27 and reopens at edge 28
4. Dwell obstruction: serve at edge 0 with `door_block` high for the single edge 10 → CLOSING at edge 26, `served_pulse` at edge 30.
5. Closing obstruction: serve at edge 0 with `door_block` at edge 22 → OPENING again at 22, no pulse at 24, `served_pulse` at edge 46.
6. Bottom boundary: `command`=10 at floor 0 → `cmd_err` 1 cycle and no motion. Then 01 then 10 → floor 0→1→0 with correct motor polarity and `busy` high throughout each move.
